// File: rtl/bram_r_reader.sv
`default_nettype none
// ============================================================================
// Module   : bram_r_reader
// Purpose  : Host-side drain engine for the result BRAM. A start pulse walks
//            a contiguous, wrapping range of BRAM R rows through the BRAM read
//            port and returns each PE-wide row on a valid/ready stream with a
//            last flag. A credit-controlled FWFT skid FIFO absorbs the fixed
//            BRAM read latency so back-pressure never drops or repeats a row.
// Ports    : clk, rstn            - clock, asynchronous active-low reset
//            start, base_addr,
//            length               - request (sampled in IDLE only)
//            busy, done           - RUN indicator, one-cycle completion pulse
//            bram_r_r_addr/_data  - BRAM R read port (data RD_LAT cycles later)
//            m_data, m_valid,
//            m_ready, m_last      - output row stream
// Revision : 1.0 - initial release
// ============================================================================
module bram_r_reader #(
  parameter int PE_COUNT   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int RD_LAT     = 1,
  parameter int BUF_DEPTH  = 4    // must be >= RD_LAT + 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [ADDR_WIDTH:0]            length,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_WIDTH-1:0]          bram_r_r_addr,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_r_data,
  output logic [PE_COUNT*DATA_WIDTH-1:0] m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last
);

  localparam int c_row_w = PE_COUNT * DATA_WIDTH;
  localparam int c_cw    = $clog2(BUF_DEPTH + 1);
  localparam int c_pw    = $clog2(BUF_DEPTH);
  localparam logic [c_cw:0]   c_depth    = (c_cw + 1)'(BUF_DEPTH);
  localparam logic [c_pw-1:0] c_last_ptr = c_pw'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_issued;
  logic [ADDR_WIDTH:0]   r_popped;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [RD_LAT-1:0]     r_vld_sr;

  logic [c_row_w-1:0]    r_mem [BUF_DEPTH];
  logic [c_pw-1:0]       r_rd_ptr, r_wr_ptr;
  logic [c_cw-1:0]       r_count;

  logic                  w_issue, w_push, w_pop, w_accept;
  logic [c_cw-1:0]       w_inflight;
  logic [ADDR_WIDTH-1:0] w_issue_addr;

  // Reads already in the BRAM pipe count against FIFO space, so every issued
  // read is guaranteed a slot when its data lands.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + c_cw'(r_vld_sr[i]);
    end
  end

  assign w_issue_addr = r_base + r_issued[ADDR_WIDTH-1:0];
  assign w_issue      = (r_state == S_RUN) && (r_issued < r_len) &&
                        (({1'b0, w_inflight} + {1'b0, r_count}) < c_depth);
  assign w_push       = r_vld_sr[RD_LAT-1];
  assign w_pop        = m_valid & m_ready;
  assign w_accept     = (r_state == S_IDLE) && start;

  // Address is combinational during an issue so the first read goes out in
  // the first RUN cycle; otherwise the last issued address is held.
  assign bram_r_r_addr = w_issue ? w_issue_addr : r_addr_hold;

  assign m_valid = (r_count != '0);
  assign m_data  = m_valid ? r_mem[r_rd_ptr] : '0;
  assign m_last  = m_valid && (r_popped == (r_len - 1'b1));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (length == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_pop && m_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request registers and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_base      <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_popped    <= '0;
      r_addr_hold <= '0;
    end else begin
      if (w_accept) begin
        r_base   <= base_addr;
        r_len    <= length;
        r_issued <= '0;
        r_popped <= '0;
      end else begin
        if (w_issue) begin
          r_issued    <= r_issued + 1'b1;
          r_addr_hold <= w_issue_addr;
        end
        if (w_pop) r_popped <= r_popped + 1'b1;
      end
    end
  end

  // Issue-valid shift register: the tail bit marks the cycle in which the
  // BRAM data for an issued read is present and gets pushed.
  if (RD_LAT == 1) begin : g_sr_single
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_vld_sr <= '0;
      else       r_vld_sr <= w_issue;
    end
  end else begin : g_sr_multi
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_vld_sr <= '0;
      else       r_vld_sr <= {r_vld_sr[RD_LAT-2:0], w_issue};
    end
  end

  // --------------------------------------------------------------------------
  // FWFT skid FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bram_r_r_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
